n2_dmem_ctrl: RTL and testbench
===============================

N2_DMEM_CTRL -- requirements
Module: N2_dmem_ctrl

Interface
REQ-001 SHALL have parameter RAM_AW, default 14, SRAM word-address width (64 KiB).
REQ-002 SHALL have parameter RAM_BASE, default 32'h0000_0000, SRAM byte base; size 4<<RAM_AW bytes.
REQ-003 SHALL have parameter PER_BASE, default 32'h1000_0000, peripheral base; PER_MASK default 32'hF000_0000 selects the match bits.
REQ-004 SHALL have parameter OT_DEPTH, default 4, maximum outstanding accepted requests.
REQ-005 SHALL have parameter PER_TIMEOUT, default 255, peripheral response watchdog, in cycles.
REQ-006 SHALL have one clock and an asynchronous active-low reset: clk in 1, rising-edge clock; resetn in 1, asynchronous active-low reset.
REQ-007 SHALL have the LSU-side ports:
- data_req_i in 1
- data_we_i in 1
- data_addr_i in 32
- data_wdata_i in 32
- data_wstrb_i in 4
- data_gnt_o out 1, combinational accept
- data_ready_o out 1, registered response
- data_rdata_o out 32
REQ-008 SHALL have the SRAM ports: ram_en_o out 1; ram_we_o out 4, byte write enables; ram_addr_o out RAM_AW; ram_wdata_o out 32; ram_rdata_i in 32, valid one cycle after ram_en_o.
REQ-009 SHALL have the peripheral ports: per_req_o out 1; per_we_o out 1; per_addr_o out 32; per_wdata_o out 32; per_wstrb_o out 4; per_gnt_i in 1; per_ready_i in 1; per_rdata_i in 32.
REQ-010 SHALL have the error ports: bus_err_o out 1, one-cycle pulse; err_addr_o out 32, address of the last errored request.

Function
REQ-011 SHALL decode the target combinationally from data_addr_i: TGT_RAM if inside the SRAM window; else TGT_PER if (addr & PER_MASK) == PER_BASE; else TGT_ERR.
REQ-012 SHALL allow acceptance only when cnt < OT_DEPTH and (cnt == 0 or target == cur_tgt); cnt is the outstanding counter, cur_tgt the target of the outstanding requests.
REQ-013 TGT_RAM SHALL be accepted as data_gnt_o = ram_en_o = data_req_i & allow, with ram_addr_o = data_addr_i[RAM_AW+1:2], and ram_we_o = data_wstrb_i when data_we_i else 4'b0000.
REQ-014 TGT_PER SHALL drive per_req_o = data_req_i & allow, pass addr/we/wdata/wstrb through, and set data_gnt_o = per_gnt_i & per_req_o.
REQ-015 TGT_ERR SHALL be accepted with data_gnt_o = data_req_i & allow; no external access is made.
REQ-016 RAM response: grant in cycle T; SHALL register ram_rdata_i in T+1; data_ready_o SHALL be high in T+2 for loads and stores alike (rdata is don't-care for stores).
REQ-017 PER response: per_ready_i in cycle R SHALL produce data_ready_o in R+1 with data_rdata_o = per_rdata_i sampled at R.
REQ-018 ERR response: grant in T SHALL produce data_ready_o in T+1 with data_rdata_o = 0, plus bus_err_o pulse in T+1 and err_addr_o updated.
REQ-019 Watchdog: while cnt > 0 and cur_tgt == TGT_PER, a counter SHALL increment each cycle without per_ready_i and clear on per_ready_i or when cnt == 0.
REQ-020 On reaching PER_TIMEOUT the block SHALL emit a synthesized response (data_ready_o, rdata 0, bus_err_o, err_addr_o = oldest outstanding address from a small OT_DEPTH address FIFO), decrement cnt and restart the counter.
REQ-021 cnt SHALL increment on grant and decrement on response-completion; simultaneous grant and completion SHALL leave cnt unchanged.
REQ-022 The address FIFO pointers SHALL wrap modulo OT_DEPTH.
REQ-023 per_ready_i arriving with cnt == 0 or cur_tgt != TGT_PER SHALL be ignored; no data_ready_o is produced.
REQ-024 Responses SHALL be returned to the LSU strictly in grant order; at most one data_ready_o per cycle.

Reset
REQ-025 On resetn low, asynchronously: data_ready_o, bus_err_o, cnt, watchdog counter, FIFO pointers and the RAM response pipe SHALL be 0; cur_tgt = TGT_RAM; data_rdata_o = 0; err_addr_o = 0.
REQ-026 Reset mid-transaction SHALL discard all outstanding requests; late peripheral responses are ignored per REQ-023.

Structure
REQ-027 dmem_tgt_e (TGT_RAM, TGT_PER, TGT_ERR) and the default address-map constants SHALL live in NanoCore_pkg.
REQ-028 The block SHALL be a single module with no sub-module; the address FIFO is an inline register array.

Verification
REQ-029 RAM load at 0x0000_0010, ram_rdata_i = 0x1122_3344 -> gnt same cycle, ram_addr_o = 4, data_ready_o two cycles later with rdata 0x1122_3344.
REQ-030 Four back-to-back RAM stores, then a fifth with no response yet -> fifth gnt held low until cnt < 4; four data_ready_o pulses in order.
REQ-031 Peripheral load at 0x1000_0004, then RAM load requested while the peripheral is outstanding -> RAM gnt low until the peripheral response (per_rdata_i = 0xCAFE_0001) is returned; then the RAM gnt is given.
REQ-032 Load from 0x8000_0000 -> data_ready_o next cycle, rdata 0, bus_err_o pulse, err_addr_o = 0x8000_0000.
REQ-033 Peripheral load with per_gnt_i = 1 and no per_ready_i for 255 cycles -> synthesized data_ready_o with bus_err_o and err_addr_o = 0x1000_0004; cnt returns to 0.
REQ-034 resetn asserted with two peripheral requests outstanding, then per_ready_i pulsed -> no data_ready_o; all outputs at reset values.

Source files
------------

// File: rtl/NanoCore_pkg.sv
// NanoCore_pkg
//   Shared types and default address map for the NanoCore data-memory path.
//   dmem_tgt_e    : decoded target of an LSU data access
//   DMEM_*        : default address-map / sizing constants
//   dmem_decode() : address -> target classification
package NanoCore_pkg;

    typedef enum logic [1:0] {
        TGT_RAM = 2'd0,
        TGT_PER = 2'd1,
        TGT_ERR = 2'd2
    } dmem_tgt_e;

    localparam int unsigned DMEM_RAM_AW      = 14;
    localparam logic [31:0] DMEM_RAM_BASE    = 32'h0000_0000;
    localparam logic [31:0] DMEM_PER_BASE    = 32'h1000_0000;
    localparam logic [31:0] DMEM_PER_MASK    = 32'hF000_0000;
    localparam int unsigned DMEM_OT_DEPTH    = 4;
    localparam int unsigned DMEM_PER_TIMEOUT = 255;

    // The SRAM window check is done in 33 bits so a window ending exactly at
    // 4 GiB does not wrap.
    function automatic dmem_tgt_e dmem_decode(
        input logic [31:0] addr,
        input logic [31:0] ram_base,
        input logic [32:0] ram_size,
        input logic [31:0] per_base,
        input logic [31:0] per_mask
    );
        logic [32:0] offset;
        offset = {1'b0, addr} - {1'b0, ram_base};
        if ((addr >= ram_base) && (offset < ram_size)) begin
            return TGT_RAM;
        end
        if ((addr & per_mask) == per_base) begin
            return TGT_PER;
        end
        return TGT_ERR;
    endfunction

endpackage

// File: rtl/n2_dmem_ctrl.sv
// n2_dmem_ctrl
//   Data-memory controller between the LSU and the SRAM / peripheral bus.
//   Routes each request by address, keeps up to OT_DEPTH requests in flight
//   (all to the same target), returns responses in grant order, and turns
//   unmapped accesses and silent peripherals into bus errors.
// Ports
//   clk, resetn          : clock, asynchronous active-low reset
//   data_*_i / data_*_o  : LSU request (combinational grant) and registered response
//   ram_*                : synchronous SRAM, read data one cycle after ram_en_o
//   per_*                : peripheral bus with its own grant and ready
//   bus_err_o            : one-cycle pulse alongside an errored response
//   err_addr_o           : address of the most recent errored request
module n2_dmem_ctrl
    import NanoCore_pkg::*;
#(
    parameter int unsigned RAM_AW      = DMEM_RAM_AW,
    parameter logic [31:0] RAM_BASE    = DMEM_RAM_BASE,
    parameter logic [31:0] PER_BASE    = DMEM_PER_BASE,
    parameter logic [31:0] PER_MASK    = DMEM_PER_MASK,
    parameter int unsigned OT_DEPTH    = DMEM_OT_DEPTH,
    parameter int unsigned PER_TIMEOUT = DMEM_PER_TIMEOUT
) (
    input  logic              clk,
    input  logic              resetn,
    // LSU side
    input  logic              data_req_i,
    input  logic              data_we_i,
    input  logic [31:0]       data_addr_i,
    input  logic [31:0]       data_wdata_i,
    input  logic [3:0]        data_wstrb_i,
    output logic              data_gnt_o,
    output logic              data_ready_o,
    output logic [31:0]       data_rdata_o,
    // SRAM
    output logic              ram_en_o,
    output logic [3:0]        ram_we_o,
    output logic [RAM_AW-1:0] ram_addr_o,
    output logic [31:0]       ram_wdata_o,
    input  logic [31:0]       ram_rdata_i,
    // Peripheral bus
    output logic              per_req_o,
    output logic              per_we_o,
    output logic [31:0]       per_addr_o,
    output logic [31:0]       per_wdata_o,
    output logic [3:0]        per_wstrb_o,
    input  logic              per_gnt_i,
    input  logic              per_ready_i,
    input  logic [31:0]       per_rdata_i,
    // Errors
    output logic              bus_err_o,
    output logic [31:0]       err_addr_o
);

    localparam int CNT_W = $clog2(OT_DEPTH + 1);
    localparam int PTR_W = (OT_DEPTH > 1) ? $clog2(OT_DEPTH) : 1;
    localparam int WD_W  = $clog2(PER_TIMEOUT + 1);

    localparam logic [32:0]      RAM_SIZE = 33'(4) << RAM_AW;
    localparam logic [CNT_W-1:0] OT_MAX   = CNT_W'(OT_DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(OT_DEPTH - 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(PER_TIMEOUT - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    dmem_tgt_e        cur_tgt_q,   cur_tgt_d;
    logic [WD_W-1:0]  wdog_q,      wdog_d;
    logic [PTR_W-1:0] wr_ptr_q,    wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q,    rd_ptr_d;
    logic             ram_pend_q,  ram_pend_d;
    logic             ready_q,     ready_d;
    logic [31:0]      rdata_q,     rdata_d;
    logic             bus_err_q,   bus_err_d;
    logic [31:0]      err_addr_q,  err_addr_d;

    // Addresses of granted requests, oldest at rd_ptr_q; only the watchdog
    // needs to look back at it.
    logic [31:0]      addr_fifo_q [OT_DEPTH];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // ------------------------------------------------------------------
    // Decode and accept
    // ------------------------------------------------------------------
    dmem_tgt_e tgt;
    logic      allow;
    logic      err_gnt;
    logic      per_active;
    logic      per_resp;
    logic      wd_fire;
    logic      resp_fire;

    always_comb begin
        tgt   = dmem_decode(data_addr_i, RAM_BASE, RAM_SIZE, PER_BASE, PER_MASK);
        // Only one target may have requests in flight, which is what keeps
        // responses from different targets from overtaking each other.
        allow = (cnt_q < OT_MAX) && ((cnt_q == '0) || (tgt == cur_tgt_q));
    end

    assign ram_en_o    = data_req_i & allow & (tgt == TGT_RAM);
    assign ram_we_o    = data_we_i ? data_wstrb_i : 4'b0000;
    assign ram_addr_o  = data_addr_i[RAM_AW+1:2];
    assign ram_wdata_o = data_wdata_i;

    assign per_req_o   = data_req_i & allow & (tgt == TGT_PER);
    assign per_we_o    = data_we_i;
    assign per_addr_o  = data_addr_i;
    assign per_wdata_o = data_wdata_i;
    assign per_wstrb_o = data_wstrb_i;

    assign err_gnt     = data_req_i & allow & (tgt == TGT_ERR);
    assign data_gnt_o  = ram_en_o | (per_req_o & per_gnt_i) | err_gnt;

    // A peripheral ready only counts while peripheral requests are owed;
    // anything else (e.g. a late reply after reset) is dropped.
    assign per_active  = (cnt_q != '0) && (cur_tgt_q == TGT_PER);
    assign per_resp    = per_active & per_ready_i;
    assign wd_fire     = per_active & ~per_ready_i & (wdog_q == WD_LAST);

    // Sources are mutually exclusive: each needs cur_tgt (or, for an
    // unmapped access, the accept rule) to point at its own target.
    assign resp_fire   = ram_pend_q | per_resp | wd_fire | err_gnt;

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        cnt_d      = cnt_q + CNT_W'(data_gnt_o) - CNT_W'(resp_fire);
        cur_tgt_d  = data_gnt_o ? tgt : cur_tgt_q;
        wr_ptr_d   = data_gnt_o ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d   = resp_fire  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        ram_pend_d = ram_en_o;

        if (!per_active || per_ready_i || wd_fire) begin
            wdog_d = '0;
        end else begin
            wdog_d = wdog_q + 1'b1;
        end

        ready_d    = resp_fire;
        bus_err_d  = wd_fire | err_gnt;
        rdata_d    = rdata_q;
        err_addr_d = err_addr_q;
        if (ram_pend_q) begin
            rdata_d = ram_rdata_i;
        end else if (per_resp) begin
            rdata_d = per_rdata_i;
        end else if (wd_fire) begin
            rdata_d    = '0;
            err_addr_d = addr_fifo_q[rd_ptr_q];
        end else if (err_gnt) begin
            rdata_d    = '0;
            err_addr_d = data_addr_i;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q      <= '0;
            cur_tgt_q  <= TGT_RAM;
            wdog_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ram_pend_q <= 1'b0;
            ready_q    <= 1'b0;
            rdata_q    <= '0;
            bus_err_q  <= 1'b0;
            err_addr_q <= '0;
        end else begin
            cnt_q      <= cnt_d;
            cur_tgt_q  <= cur_tgt_d;
            wdog_q     <= wdog_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ram_pend_q <= ram_pend_d;
            ready_q    <= ready_d;
            rdata_q    <= rdata_d;
            bus_err_q  <= bus_err_d;
            err_addr_q <= err_addr_d;
        end
    end

    // Storage needs no reset: an entry is always written before it is read.
    always_ff @(posedge clk) begin
        if (data_gnt_o) begin
            addr_fifo_q[wr_ptr_q] <= data_addr_i;
        end
    end

    assign data_ready_o = ready_q;
    assign data_rdata_o = rdata_q;
    assign bus_err_o    = bus_err_q;
    assign err_addr_o   = err_addr_q;

endmodule

// File: tb/tb_n2_dmem_ctrl.sv
// tb_n2_dmem_ctrl
//   Randomised and directed stimulus for n2_dmem_ctrl with an SRAM model, a
//   peripheral model, and a scoreboard of expected responses in grant order.
module tb_n2_dmem_ctrl;

    localparam int TB_TIMEOUT = 255;

    logic        clk = 1'b0;
    logic        resetn;
    logic        data_req_i, data_we_i;
    logic [31:0] data_addr_i, data_wdata_i;
    logic [3:0]  data_wstrb_i;
    logic        data_gnt_o, data_ready_o;
    logic [31:0] data_rdata_o;
    logic        ram_en_o;
    logic [3:0]  ram_we_o;
    logic [13:0] ram_addr_o;
    logic [31:0] ram_wdata_o;
    logic [31:0] ram_rdata_i;
    logic        per_req_o, per_we_o;
    logic [31:0] per_addr_o, per_wdata_o;
    logic [3:0]  per_wstrb_o;
    logic        per_gnt_i, per_ready_i;
    logic [31:0] per_rdata_i;
    logic        bus_err_o;
    logic [31:0] err_addr_o;

    n2_dmem_ctrl dut (
        .clk(clk), .resetn(resetn),
        .data_req_i(data_req_i), .data_we_i(data_we_i), .data_addr_i(data_addr_i),
        .data_wdata_i(data_wdata_i), .data_wstrb_i(data_wstrb_i),
        .data_gnt_o(data_gnt_o), .data_ready_o(data_ready_o), .data_rdata_o(data_rdata_o),
        .ram_en_o(ram_en_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
        .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i),
        .per_req_o(per_req_o), .per_we_o(per_we_o), .per_addr_o(per_addr_o),
        .per_wdata_o(per_wdata_o), .per_wstrb_o(per_wstrb_o),
        .per_gnt_i(per_gnt_i), .per_ready_i(per_ready_i), .per_rdata_i(per_rdata_i),
        .bus_err_o(bus_err_o), .err_addr_o(err_addr_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic check_range(input string name, input int got, input int lo, input int hi);
        n_tests++;
        if (got < lo || got > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, got, lo, hi);
        end
    endtask

    // ---------------- reference model (address map + memory) ----------------
    function automatic int tb_tgt(input logic [31:0] a);
        if (a < 32'h0001_0000) return 0;       // 64 KiB SRAM at 0
        if (a[31:28] == 4'h1)  return 1;       // peripheral region
        return 2;                              // unmapped
    endfunction

    function automatic logic [31:0] init_word(input int w);
        return (32'(w) * 32'h9E37_79B9) ^ 32'h0BAD_F00D;
    endfunction

    function automatic logic [31:0] per_func(input logic [31:0] a);
        return 32'hCAFE_0000 | ((a >> 2) & 32'h0000_FFFF);
    endfunction

    logic [31:0] ref_mem [int];
    logic [31:0] sram    [int];

    function automatic logic [31:0] ref_rd(input int w);
        return ref_mem.exists(w) ? ref_mem[w] : init_word(w);
    endfunction

    function automatic logic [31:0] sram_rd(input int w);
        return sram.exists(w) ? sram[w] : init_word(w);
    endfunction

    // ---------------- SRAM device model ----------------
    logic [31:0] sram_word;
    always @(posedge clk) begin
        if (ram_en_o) begin
            sram_word = sram_rd(int'(ram_addr_o));
            ram_rdata_i <= sram_word;
            for (int b = 0; b < 4; b++)
                if (ram_we_o[b]) sram_word[8*b +: 8] = ram_wdata_o[8*b +: 8];
            sram[int'(ram_addr_o)] = sram_word;
        end else begin
            ram_rdata_i <= $urandom;
        end
    end

    // ---------------- peripheral device model ----------------
    typedef struct { logic [31:0] data; int due; } pr_t;
    pr_t  per_q[$];
    logic per_mute = 1'b0;
    logic per_ready_m = 1'b0;
    logic per_ready_f = 1'b0;
    int   per_fixed_delay = -1;
    int   per_ready_cnt = 0;
    int   last_per_ready_cyc = 0;
    assign per_ready_i = per_ready_m | per_ready_f;

    always @(posedge clk) begin
        per_gnt_i   <= ($urandom_range(0, 3) != 0);
        per_ready_m <= 1'b0;
        per_rdata_i <= $urandom;
        if (per_q.size() > 0 && !per_mute && cyc >= per_q[0].due) begin
            per_ready_m        <= 1'b1;
            per_rdata_i        <= per_q[0].data;
            last_per_ready_cyc <= cyc + 1;
            per_ready_cnt      <= per_ready_cnt + 1;
            void'(per_q.pop_front());
        end
        if (resetn && per_req_o && per_gnt_i)
            per_q.push_back('{per_func(per_addr_o),
                cyc + ((per_fixed_delay >= 0) ? per_fixed_delay : int'($urandom_range(1, 4)))});
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic        chk_data;
        logic [31:0] rdata;
        logic        err;
        logic [31:0] eaddr;
        int          min_c;
        int          max_c;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;
    int   n_rsp = 0;
    logic exp_timeout = 1'b0;

    always @(negedge clk) begin
        if (resetn) begin
            if (data_ready_o) begin
                if (sb.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_ready: data_ready_o=1 with nothing outstanding (cycle %0d)", cyc);
                end else begin
                    mon_e = sb.pop_front();
                    n_rsp++;
                    check("rsp_bus_err", 32'(bus_err_o), 32'(mon_e.err));
                    if (mon_e.chk_data) check("rsp_rdata", data_rdata_o, mon_e.rdata);
                    if (mon_e.err)      check("rsp_err_addr", err_addr_o, mon_e.eaddr);
                    if (mon_e.min_c >= 0) check_range("rsp_latency", cyc, mon_e.min_c, mon_e.max_c);
                    $display("[TB] rsp %0d cyc %0d rdata %08h err %0d", n_rsp, cyc, data_rdata_o, bus_err_o);
                end
            end else if (bus_err_o) begin
                n_tests++; n_fail++;
                $display("FAIL stray_bus_err: bus_err_o=1 without data_ready_o (cycle %0d)", cyc);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input int limit,
                         output int gcyc, output int waited);
        int          t;
        logic [31:0] v;
        exp_t        e;
        @(posedge clk); #1;
        data_req_i = 1'b1; data_we_i = we; data_addr_i = addr;
        data_wdata_i = wdata; data_wstrb_i = wstrb;
        waited = 0; gcyc = -1;
        forever begin
            @(negedge clk);
            if (data_gnt_o) break;
            waited++;
            if (waited > limit) begin
                n_tests++; n_fail++;
                $display("FAIL gnt_wait: no data_gnt_o for addr %08h after %0d cycles", addr, waited);
                data_req_i = 1'b0;
                return;
            end
        end
        gcyc = cyc;
        t = tb_tgt(addr);
        e = '{1'b0, 32'h0, 1'b0, 32'h0, -1, -1};
        if (t == 0) begin
            check("gnt_ram_en", 32'(ram_en_o), 32'd1);
            check("gnt_ram_addr", 32'(ram_addr_o), (addr >> 2) & 32'h3FFF);
            check("gnt_ram_we", 32'(ram_we_o), we ? 32'(wstrb) : 32'd0);
            v = ref_rd(int'(addr >> 2));
            if (we) begin
                for (int b = 0; b < 4; b++)
                    if (wstrb[b]) v[8*b +: 8] = wdata[8*b +: 8];
                ref_mem[int'(addr >> 2)] = v;
            end
            e = '{!we, v, 1'b0, 32'h0, gcyc + 2, gcyc + 2};
        end else if (t == 1) begin
            check("gnt_per_addr", per_addr_o, addr);
            check("gnt_per_ctl", {27'h0, per_we_o, per_wstrb_o}, {27'h0, we, wstrb});
            if (exp_timeout)
                e = '{1'b1, 32'h0, 1'b1, addr, gcyc + TB_TIMEOUT, gcyc + TB_TIMEOUT + 2};
            else
                e = '{!we, per_func(addr), 1'b0, 32'h0, -1, -1};
        end else begin
            check("gnt_err_no_access", {30'h0, ram_en_o, per_req_o}, 32'd0);
            e = '{1'b1, 32'h0, 1'b1, addr, gcyc + 1, gcyc + 1};
        end
        sb.push_back(e);
    endtask

    task automatic idle();
        @(posedge clk); #1;
        data_req_i = 1'b0;
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        while (sb.size() != 0 && n < limit) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            n_tests++; n_fail++;
            $display("FAIL drain: %0d responses still owed after %0d cycles", sb.size(), limit);
            sb.delete();
        end
        @(posedge clk);
    endtask

    // ---------------- main sequence ----------------
    int          g, w, g2, w2, cnt_before, k;
    logic        we_r;
    logic [31:0] a_r;
    logic [3:0]  s_r;

    initial begin
        resetn = 1'b0;
        data_req_i = 1'b0; data_we_i = 1'b0; data_addr_i = '0;
        data_wdata_i = '0; data_wstrb_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ready", 32'(data_ready_o), 32'd0);
        check("reset_bus_err", 32'(bus_err_o), 32'd0);
        check("reset_rdata", data_rdata_o, 32'd0);
        check("reset_err_addr", err_addr_o, 32'd0);
        @(posedge clk); #1 resetn = 1'b1;

        // RAM load at 0x10
        sram[4] = 32'h1122_3344; ref_mem[4] = 32'h1122_3344;
        issue(1'b0, 32'h0000_0010, 32'h0, 4'h0, 50, g, w);
        check("ram_load_gnt_wait", 32'(w), 32'd0);
        idle(); drain(50);

        // five back-to-back stores then read back
        for (int i = 0; i < 5; i++)
            issue(1'b1, 32'(32 + 4 * i), 32'hA000_0000 + 32'(i), 4'hF, 50, g, w);
        for (int i = 0; i < 5; i++)
            issue(1'b0, 32'(32 + 4 * i), 32'h0, 4'h0, 50, g, w);
        idle(); drain(50);

        // peripheral load blocks a following RAM load until it returns
        per_fixed_delay = 6;
        issue(1'b0, 32'h1000_0004, 32'h0, 4'h0, 50, g, w);
        cnt_before = per_ready_cnt;
        issue(1'b0, 32'h0000_0010, 32'h0, 4'h0, 50, g2, w2);
        check("ram_after_per_ready_seen", 32'(per_ready_cnt - cnt_before), 32'd1);
        check_range("ram_after_per_gnt_cycle", g2, last_per_ready_cyc + 1, g2);
        idle(); drain(50);
        per_fixed_delay = -1;

        // unmapped load
        issue(1'b0, 32'h8000_0000, 32'h0, 4'h0, 50, g, w);
        idle(); drain(20);

        // randomised traffic
        for (int i = 0; i < 200; i++) begin
            k    = int'($urandom_range(0, 9));
            we_r = 1'($urandom_range(0, 1));
            s_r  = 4'($urandom_range(1, 15));
            if (k < 5)
                a_r = ($urandom_range(0, 7) == 0) ? 32'h0000_FFFC : (32'($urandom_range(0, 63)) << 2);
            else if (k < 8)
                a_r = 32'h1000_0000 + (32'($urandom_range(0, 255)) << 2);
            else begin
                case ($urandom_range(0, 3))
                    0: a_r = 32'h0001_0000;
                    1: a_r = 32'h8000_0000;
                    2: a_r = 32'h2000_0000 | ($urandom & 32'h0FFF_FFFC);
                    default: a_r = 32'hFFFF_FFFC;
                endcase
            end
            issue(we_r, a_r, $urandom, s_r, 100, g, w);
            if ($urandom_range(0, 3) == 0) idle();
        end
        idle(); drain(100);

        // peripheral never answers: watchdog response
        per_mute = 1'b1; exp_timeout = 1'b1;
        issue(1'b0, 32'h1000_0004, 32'h0, 4'h0, 50, g, w);
        idle(); drain(400);
        exp_timeout = 1'b0; per_q.delete(); per_mute = 1'b0;
        issue(1'b0, 32'h0000_0020, 32'h0, 4'h0, 50, g, w);
        check("post_timeout_gnt_wait", 32'(w), 32'd0);
        idle(); drain(20);

        // reset with two peripheral requests outstanding
        per_mute = 1'b1;
        issue(1'b0, 32'h1000_0008, 32'h0, 4'h0, 50, g, w);
        issue(1'b0, 32'h1000_000C, 32'h0, 4'h0, 50, g, w);
        idle();
        repeat (3) @(posedge clk);
        #1 resetn = 1'b0;
        sb.delete(); per_q.delete();
        @(negedge clk);
        check("midreset_ready", 32'(data_ready_o), 32'd0);
        check("midreset_bus_err", 32'(bus_err_o), 32'd0);
        check("midreset_rdata", data_rdata_o, 32'd0);
        check("midreset_err_addr", err_addr_o, 32'd0);
        @(posedge clk); #1 resetn = 1'b1; per_mute = 1'b0;
        @(posedge clk); #1 per_ready_f = 1'b1;
        @(posedge clk); #1 per_ready_f = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("late_per_ready_ignored", 32'(data_ready_o), 32'd0);
        end
        issue(1'b0, 32'h0000_0010, 32'h0, 4'h0, 50, g, w);
        check("post_reset_gnt_wait", 32'(w), 32'd0);
        idle(); drain(20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1, "global timeout");
    end

endmodule
